// File: rtl/egress_frame_reader_pkg.sv
// Shared types and constants for the egress frame reader: MAC bus structs, RAM word geometry,
// FSM state encoding and frame-length helpers.
package egress_frame_reader_pkg;

   localparam int unsigned RamWordWidth = 144;
   localparam int unsigned DataWidth    = 128;
   localparam int unsigned AddrWidth    = 18;
   localparam int unsigned LenWidth     = 11;

   typedef struct packed {
      logic        start;
      logic        data_valid;
      logic [2:0]  bytes_valid;
      logic [31:0] data;
   } EthernetTxBus;

   typedef struct packed {
      logic        start;
      logic        data_valid;
      logic [2:0]  bytes_valid;
      logic [31:0] data;
   } EthernetRxBus;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWaitMac,
      StData,
      StDone
   } state_e;

   function automatic logic [LenWidth-1:0] len_to_words(input logic [LenWidth-1:0] len);
      logic [LenWidth:0] sum;
      sum = {1'b0, len} + (LenWidth + 1)'(15);
      return LenWidth'(sum >> 4);
   endfunction

   function automatic logic [LenWidth-1:0] len_to_beats(input logic [LenWidth-1:0] len);
      logic [LenWidth:0] sum;
      sum = {1'b0, len} + (LenWidth + 1)'(3);
      return LenWidth'(sum >> 2);
   endfunction

   function automatic logic [2:0] last_beat_bytes(input logic [LenWidth-1:0] len);
      return (len[1:0] == 2'd0) ? 3'd4 : {1'b0, len[1:0]};
   endfunction

endpackage

// File: rtl/egress_prefetch_fifo.sv
// Synchronous FIFO holding prefetched RAM words; exposes occupancy for the read-credit logic.
// Depth must be a power of two and at least 2 so the pointers wrap naturally.
module egress_prefetch_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 128,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic [CntW-1:0]  count_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/egress_frame_reader.sv
// Reads one frame per descriptor from packet RAM through a prefetch FIFO and streams it to the
// MAC as gapless 32-bit beats. All outputs are registered.
module egress_frame_reader
   import egress_frame_reader_pkg::*;
#(
   parameter int unsigned RD_LATENCY     = 2,
   parameter int unsigned PREFETCH_DEPTH = 4,
   parameter int unsigned MAX_LEN        = 1536
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    desc_valid,
   output logic                    desc_ready,
   input  logic [AddrWidth-1:0]    desc_addr,
   input  logic [LenWidth-1:0]     desc_len,
   output logic                    ram_rd_en,
   output logic [AddrWidth-1:0]    ram_rd_addr,
   input  logic [RamWordWidth-1:0] ram_rd_data,
   input  logic                    mac_tx_ready,
   output EthernetTxBus            mac_tx_bus,
   output logic                    frame_done,
   output logic                    len_err
);

   localparam int unsigned CntW = $clog2(PREFETCH_DEPTH + 1);

   state_e                state_q, state_d;
   logic [AddrWidth-1:0]  addr_q, addr_d;
   logic [AddrWidth-1:0]  rd_addr_q, rd_addr_d;
   logic                  rd_en_q, rd_en_d;
   logic [LenWidth-1:0]   words_left_q, words_left_d;
   logic [LenWidth-1:0]   beats_left_q, beats_left_d;
   logic [1:0]            lane_q, lane_d;
   logic [2:0]            last_bytes_q, last_bytes_d;
   logic [CntW-1:0]       target_q, target_d;
   logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
   EthernetTxBus          bus_q, bus_d;
   logic                  desc_ready_q, desc_ready_d;
   logic                  frame_done_q, frame_done_d;
   logic                  len_err_q, len_err_d;

   logic                  fifo_push, fifo_pop, fifo_empty;
   logic [DataWidth-1:0]  fifo_rdata;
   logic [CntW-1:0]       fifo_count;
   logic [31:0]           lane_word;
   logic [LenWidth-1:0]   new_words;
   int unsigned           outstanding;
   logic                  rd_credit;
   logic                  unused_ram_hi;

   assign unused_ram_hi = ^ram_rd_data[RamWordWidth-1:DataWidth];

   // Read data is valid exactly RD_LATENCY cycles after the strobe; no handshake from the RAM.
   assign rd_vld_d  = RD_LATENCY'({rd_vld_q, rd_en_q});
   assign fifo_push = rd_vld_q[RD_LATENCY-1];

   egress_prefetch_fifo #(
      .Depth (PREFETCH_DEPTH),
      .Width (DataWidth)
   ) u_prefetch_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (fifo_push),
      .wdata_i (ram_rd_data[DataWidth-1:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   // Credit counts buffered words plus every read still in the RAM pipeline.
   always_comb begin
      outstanding = 32'(fifo_count) + 32'(rd_en_q);
      for (int i = 0; i < int'(RD_LATENCY); i++) outstanding += 32'(rd_vld_q[i]);
   end
   assign rd_credit = (outstanding < PREFETCH_DEPTH);

   always_comb begin
      case (lane_q)
         2'd0:    lane_word = fifo_rdata[127:96];
         2'd1:    lane_word = fifo_rdata[95:64];
         2'd2:    lane_word = fifo_rdata[63:32];
         default: lane_word = fifo_rdata[31:0];
      endcase
   end

   assign new_words = len_to_words(desc_len);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rd_addr_d    = rd_addr_q;
      rd_en_d      = 1'b0;
      words_left_d = words_left_q;
      beats_left_d = beats_left_q;
      lane_d       = lane_q;
      last_bytes_d = last_bytes_q;
      target_d     = target_q;
      bus_d        = '0;
      frame_done_d = 1'b0;
      len_err_d    = 1'b0;
      fifo_pop     = 1'b0;

      if ((state_q == StFetch || state_q == StWaitMac || state_q == StData) &&
          words_left_q != '0 && rd_credit) begin
         rd_en_d      = 1'b1;
         rd_addr_d    = addr_q;
         addr_d       = addr_q + AddrWidth'(1);
         words_left_d = words_left_q - LenWidth'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (desc_valid && desc_ready_q) begin
               if (desc_len == '0 || 32'(desc_len) > MAX_LEN) begin
                  len_err_d = 1'b1;
               end else begin
                  state_d      = StFetch;
                  addr_d       = desc_addr;
                  words_left_d = new_words;
                  beats_left_d = len_to_beats(desc_len);
                  last_bytes_d = last_beat_bytes(desc_len);
                  lane_d       = 2'd0;
                  target_d     = (32'(new_words) > PREFETCH_DEPTH) ? CntW'(PREFETCH_DEPTH)
                                                                  : CntW'(new_words);
               end
            end
         end
         StFetch: begin
            if (fifo_count >= target_q) state_d = StWaitMac;
         end
         StWaitMac: begin
            if (mac_tx_ready) begin
               bus_d.start = 1'b1;
               state_d     = StData;
            end
         end
         StData: begin
            bus_d.data_valid  = 1'b1;
            bus_d.data        = lane_word;
            bus_d.bytes_valid = (beats_left_q == LenWidth'(1)) ? last_bytes_q : 3'd4;
            beats_left_d      = beats_left_q - LenWidth'(1);
            lane_d            = lane_q + 2'd1;
            fifo_pop          = (lane_q == 2'd3) || (beats_left_q == LenWidth'(1));
            if (beats_left_q == LenWidth'(1)) state_d = StDone;
         end
         StDone: begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase

      desc_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         rd_addr_q    <= '0;
         rd_en_q      <= 1'b0;
         words_left_q <= '0;
         beats_left_q <= '0;
         lane_q       <= '0;
         last_bytes_q <= '0;
         target_q     <= '0;
         rd_vld_q     <= '0;
         bus_q        <= '0;
         desc_ready_q <= 1'b0;
         frame_done_q <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_addr_q    <= rd_addr_d;
         rd_en_q      <= rd_en_d;
         words_left_q <= words_left_d;
         beats_left_q <= beats_left_d;
         lane_q       <= lane_d;
         last_bytes_q <= last_bytes_d;
         target_q     <= target_d;
         rd_vld_q     <= rd_vld_d;
         bus_q        <= bus_d;
         desc_ready_q <= desc_ready_d;
         frame_done_q <= frame_done_d;
         len_err_q    <= len_err_d;
      end
   end

   // Four beats per word against at most one read per cycle keeps the buffer ahead of DATA.
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                    (state_q == StData) |-> !fifo_empty)
      else $error("prefetch buffer empty while streaming");

   assign desc_ready  = desc_ready_q;
   assign ram_rd_en   = rd_en_q;
   assign ram_rd_addr = rd_addr_q;
   assign mac_tx_bus  = bus_q;
   assign frame_done  = frame_done_q;
   assign len_err     = len_err_q;

endmodule
